// File: rtl/uart_param_pkg.sv
// uart_param shared types and constants.
// State encodings, parity modes and oversampling points.
package uart_param_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;

  localparam int OSR_TICKS  = 16;
  localparam int START_TICK = 7;

endpackage

// File: rtl/uart_param_fifo.sv
// First-word-fall-through FIFO, occupancy tracked by a count register.
// Head word reads as zero while empty.
module uart_param_fifo #(
  parameter int W  = 8,
  parameter int AW = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr,
  input  logic [W-1:0] wr_data,
  input  logic         rd,
  output logic [W-1:0] rd_data,
  output logic         empty,
  output logic         full
);

  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   cnt;
  logic          we;
  logic          re;

  assign re      = rd && !empty;
  // a pop frees the slot, so a write to a full FIFO still lands
  assign we      = wr && (!full || re);
  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign rd_data = empty ? '0 : mem[rptr];

  always_ff @(posedge clk) begin
    if (we) mem[wptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (we) wptr <= wptr + AW'(1);
      if (re) rptr <= rptr + AW'(1);
      if (we && !re)
        cnt <= cnt + (AW+1)'(1);
      else if (re && !we)
        cnt <= cnt - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/uart_param.sv
// Parametrised full-duplex UART with runtime divisor, parity and stop mode.
// RX and TX are each buffered by a FWFT FIFO.
module uart_param
  import uart_param_pkg::*;
#(
  parameter int DBIT   = 8,
  parameter int DVSR_W = 11,
  parameter int FIFO_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DVSR_W-1:0] dvsr,
  input  logic [1:0]        cfg_parity,
  input  logic              cfg_stop2,
  input  logic              rx,
  output logic              tx,
  input  logic              wr_uart,
  input  logic [DBIT-1:0]   wr_data,
  input  logic              rd_uart,
  output logic [DBIT-1:0]   rd_data,
  output logic [1:0]        rd_err,
  output logic              rx_empty,
  output logic              rx_full,
  output logic              tx_empty,
  output logic              tx_full,
  output logic              rx_overrun,
  input  logic              clr_overrun
);

  function automatic logic par_on(logic [1:0] m);
    return (m == PAR_ODD) || (m == PAR_EVEN);
  endfunction

  function automatic logic par_of(logic [1:0] m, logic [DBIT-1:0] d);
    return (m == PAR_ODD) ? ~^d : ^d;
  endfunction

  logic [DVSR_W-1:0] bcnt;
  logic [DVSR_W-1:0] btop;
  logic [DVSR_W-1:0] dtop;
  logic              s_tick;

  // the top count is re-latched only at a wrap
  assign dtop   = (dvsr == '0) ? '0 : dvsr - DVSR_W'(1);
  assign s_tick = (bcnt == btop);

  always_ff @(posedge clk) begin
    if (rst || s_tick) begin
      bcnt <= '0;
      btop <= dtop;
    end else begin
      bcnt <= bcnt + DVSR_W'(1);
    end
  end

  logic rx_m;
  logic rxs;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m <= 1'b1;
      rxs  <= 1'b1;
    end else begin
      rx_m <= rx;
      rxs  <= rx_m;
    end
  end

  state_t          rx_state;
  logic [3:0]      rx_t;
  logic [2:0]      rx_n;
  logic [DBIT-1:0] rx_sreg;
  logic [1:0]      rx_par;
  logic            rx_perr;
  logic            rx_ferr;
  logic            rx_hold;
  logic            rx_push;
  logic            rx_drop;
  logic [DBIT+1:0] rx_head;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state <= IDLE;
      rx_t     <= '0;
      rx_n     <= '0;
      rx_sreg  <= '0;
      rx_par   <= PAR_NONE;
      rx_perr  <= 1'b0;
      rx_ferr  <= 1'b0;
      rx_hold  <= 1'b0;
      rx_push  <= 1'b0;
    end else begin
      rx_push <= 1'b0;
      unique case (rx_state)
        IDLE: begin
          if (rx_hold) begin
            if (rxs) rx_hold <= 1'b0;
          end else if (!rxs) begin
            rx_state <= START;
            rx_t     <= '0;
            rx_par   <= cfg_parity;
            rx_perr  <= 1'b0;
          end
        end
        START: if (s_tick) begin
          if (rx_t == 4'(START_TICK)) begin
            rx_t     <= '0;
            rx_n     <= '0;
            rx_state <= rxs ? IDLE : DATA;
          end else begin
            rx_t <= rx_t + 4'd1;
          end
        end
        DATA: if (s_tick) begin
          if (rx_t == 4'(OSR_TICKS-1)) begin
            rx_t    <= '0;
            rx_sreg <= {rxs, rx_sreg[DBIT-1:1]};
            if (rx_n == 3'(DBIT-1))
              rx_state <= par_on(rx_par) ? PARITY : STOP;
            else
              rx_n <= rx_n + 3'd1;
          end else begin
            rx_t <= rx_t + 4'd1;
          end
        end
        PARITY: if (s_tick) begin
          if (rx_t == 4'(OSR_TICKS-1)) begin
            rx_t     <= '0;
            rx_perr  <= (rxs != par_of(rx_par, rx_sreg));
            rx_state <= STOP;
          end else begin
            rx_t <= rx_t + 4'd1;
          end
        end
        STOP: if (s_tick) begin
          if (rx_t == 4'(OSR_TICKS-1)) begin
            rx_t     <= '0;
            rx_ferr  <= !rxs;
            rx_hold  <= !rxs;
            rx_push  <= 1'b1;
            rx_state <= IDLE;
          end else begin
            rx_t <= rx_t + 4'd1;
          end
        end
        default: rx_state <= IDLE;
      endcase
    end
  end

  uart_param_fifo #(.W(DBIT+2), .AW(FIFO_W)) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr      (rx_push),
    .wr_data ({rx_ferr, rx_perr, rx_sreg}),
    .rd      (rd_uart),
    .rd_data (rx_head),
    .empty   (rx_empty),
    .full    (rx_full)
  );

  assign rd_data = rx_head[DBIT-1:0];
  assign rd_err  = rx_head[DBIT+1:DBIT];
  assign rx_drop = rx_push && rx_full && !rd_uart;

  always_ff @(posedge clk) begin
    if (rst)
      rx_overrun <= 1'b0;
    else if (rx_drop)
      rx_overrun <= 1'b1;
    else if (clr_overrun)
      rx_overrun <= 1'b0;
  end

  state_t          tx_state;
  logic [4:0]      tx_t;
  logic [2:0]      tx_n;
  logic [DBIT-1:0] tx_sreg;
  logic            tx_pbit;
  logic            tx_pen;
  logic            tx_stop2;
  logic            tx_go;
  logic            tx_pop;
  logic [DBIT-1:0] tx_head;

  assign tx_pop = (tx_state == IDLE) && !tx_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= IDLE;
      tx_t     <= '0;
      tx_n     <= '0;
      tx_sreg  <= '0;
      tx_pbit  <= 1'b0;
      tx_pen   <= 1'b0;
      tx_stop2 <= 1'b0;
      tx_go    <= 1'b0;
      tx       <= 1'b1;
    end else begin
      unique case (tx_state)
        IDLE: if (!tx_empty) begin
          tx_sreg  <= tx_head;
          tx_pbit  <= par_of(cfg_parity, tx_head);
          tx_pen   <= par_on(cfg_parity);
          tx_stop2 <= cfg_stop2;
          tx_go    <= 1'b0;
          tx_t     <= '0;
          tx_state <= START;
        end
        START: if (s_tick) begin
          // first tick aligns the start bit to the baud grid
          if (!tx_go) begin
            tx_go <= 1'b1;
            tx    <= 1'b0;
          end else if (tx_t == 5'(OSR_TICKS-1)) begin
            tx_t     <= '0;
            tx_n     <= '0;
            tx       <= tx_sreg[0];
            tx_state <= DATA;
          end else begin
            tx_t <= tx_t + 5'd1;
          end
        end
        DATA: if (s_tick) begin
          if (tx_t == 5'(OSR_TICKS-1)) begin
            tx_t    <= '0;
            tx_sreg <= tx_sreg >> 1;
            if (tx_n == 3'(DBIT-1)) begin
              tx       <= tx_pen ? tx_pbit : 1'b1;
              tx_state <= tx_pen ? PARITY : STOP;
            end else begin
              tx_n <= tx_n + 3'd1;
              tx   <= tx_sreg[1];
            end
          end else begin
            tx_t <= tx_t + 5'd1;
          end
        end
        PARITY: if (s_tick) begin
          if (tx_t == 5'(OSR_TICKS-1)) begin
            tx_t     <= '0;
            tx       <= 1'b1;
            tx_state <= STOP;
          end else begin
            tx_t <= tx_t + 5'd1;
          end
        end
        STOP: if (s_tick) begin
          if (tx_t == (tx_stop2 ? 5'(2*OSR_TICKS-1) : 5'(OSR_TICKS-1))) begin
            tx_t     <= '0;
            tx_state <= IDLE;
          end else begin
            tx_t <= tx_t + 5'd1;
          end
        end
        default: tx_state <= IDLE;
      endcase
    end
  end

  uart_param_fifo #(.W(DBIT), .AW(FIFO_W)) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr      (wr_uart),
    .wr_data (wr_data),
    .rd      (tx_pop),
    .rd_data (tx_head),
    .empty   (tx_empty),
    .full    (tx_full)
  );

endmodule

// File: tb/tb_uart_param.sv
// Directed bench for uart_param at dvsr=4 (64 clocks per bit).
// Second instance with a 4-deep FIFO covers RX overrun.
module tb_uart_param;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] dvsr = 11'd4;
  logic [1:0]  cfg_parity = 2'b00;
  logic        cfg_stop2 = 1'b0;
  logic        rx_drv = 1'b1;
  logic        loop = 1'b0;
  logic        wr_uart = 1'b0;
  logic [7:0]  wr_data = 8'h00;
  logic        rd_uart = 1'b0;
  logic        clr_overrun = 1'b0;
  logic        s_rd = 1'b0;
  logic        s_clr = 1'b0;

  logic       tx, rx_line;
  logic [7:0] rd_data;
  logic [1:0] rd_err;
  logic       rx_empty, rx_full, tx_empty, tx_full, rx_overrun;

  logic       s_tx;
  logic [7:0] s_rd_data;
  logic [1:0] s_rd_err;
  logic       s_rx_empty, s_rx_full, s_tx_empty, s_tx_full, s_rx_overrun;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign rx_line = loop ? tx : rx_drv;

  uart_param u_dut (
    .clk(clk), .rst(rst), .dvsr(dvsr),
    .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2),
    .rx(rx_line), .tx(tx),
    .wr_uart(wr_uart), .wr_data(wr_data),
    .rd_uart(rd_uart), .rd_data(rd_data), .rd_err(rd_err),
    .rx_empty(rx_empty), .rx_full(rx_full),
    .tx_empty(tx_empty), .tx_full(tx_full),
    .rx_overrun(rx_overrun), .clr_overrun(clr_overrun)
  );

  uart_param #(.FIFO_W(2)) u_small (
    .clk(clk), .rst(rst), .dvsr(dvsr),
    .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2),
    .rx(rx_drv), .tx(s_tx),
    .wr_uart(1'b0), .wr_data(8'h00),
    .rd_uart(s_rd), .rd_data(s_rd_data), .rd_err(s_rd_err),
    .rx_empty(s_rx_empty), .rx_full(s_rx_full),
    .tx_empty(s_tx_empty), .tx_full(s_tx_full),
    .rx_overrun(s_rx_overrun), .clr_overrun(s_clr)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write(input logic [7:0] d);
    wr_uart = 1'b1;
    wr_data = d;
    step(1);
    wr_uart = 1'b0;
  endtask

  task automatic pop();
    rd_uart = 1'b1;
    step(1);
    rd_uart = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit pe,
                            input bit pb, input bit sb);
    rx_drv = 1'b0;
    step(64);
    for (int i = 0; i < 8; i++) begin
      rx_drv = d[i];
      step(64);
    end
    if (pe) begin
      rx_drv = pb;
      step(64);
    end
    rx_drv = sb;
    step(64);
  endtask

  task automatic wait_rx(input string tag);
    int n = 0;
    while (rx_empty && n < 400) begin
      step(1);
      n++;
    end
    check(tag, rx_empty, 1'b0);
  endtask

  // c counts clocks from the first low sample; bit k is sampled mid-bit
  task automatic tx_recv(input bit pe, output logic [7:0] d,
                         output logic pb, output logic sb,
                         output int rise, output int lat);
    int lim;
    d = '0; pb = 1'b0; sb = 1'b0; rise = -1; lat = 0;
    while (tx === 1'b1 && lat < 2000) begin
      step(1);
      lat++;
    end
    check("tx_start", tx, 1'b0);
    if (tx !== 1'b0) return;
    lim = 32 + 64 * (9 + int'(pe));
    for (int c = 1; c <= lim; c++) begin
      step(1);
      if (rise < 0 && tx === 1'b1) rise = c;
      for (int k = 0; k < 8; k++)
        if (c == 96 + 64 * k) d[k] = tx;
      if (pe && c == 32 + 64 * 9) pb = tx;
      if (c == lim) sb = tx;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic       pb, sb;
    int         rise, lat, lows;

    step(2);
    check("rst_tx", tx, 1'b1);
    check("rst_rx_empty", rx_empty, 1'b1);
    check("rst_rx_full", rx_full, 1'b0);
    check("rst_tx_empty", tx_empty, 1'b1);
    check("rst_tx_full", tx_full, 1'b0);
    check("rst_overrun", rx_overrun, 1'b0);
    check("rst_rd_data", rd_data, 8'h00);
    check("rst_rd_err", rd_err, 2'b00);
    rst = 1'b0;
    step(3);

    loop = 1'b1;
    write(8'hA5);
    tx_recv(1'b0, d, pb, sb, rise, lat);
    check("a5_latency_ok", lat <= 6, 1'b1);
    check("a5_start_len", rise, 64);
    check("a5_tx_data", d, 8'hA5);
    check("a5_tx_stop", sb, 1'b1);
    wait_rx("a5_rx_ready");
    check("a5_rd_data", rd_data, 8'hA5);
    check("a5_rd_err", rd_err, 2'b00);
    pop();
    check("a5_rx_drained", rx_empty, 1'b1);

    cfg_parity = 2'b10;
    write(8'h07);
    tx_recv(1'b1, d, pb, sb, rise, lat);
    check("even_tx_data", d, 8'h07);
    check("even_tx_pbit", pb, 1'b1);
    check("even_tx_stop", sb, 1'b1);
    wait_rx("even_loop_ready");
    check("even_loop_data", rd_data, 8'h07);
    check("even_loop_err", rd_err, 2'b00);
    pop();
    loop = 1'b0;
    step(20);
    send_frame(8'h07, 1'b1, 1'b0, 1'b1);
    wait_rx("perr_ready");
    check("perr_data", rd_data, 8'h07);
    check("perr_err", rd_err, 2'b01);
    pop();

    cfg_parity = 2'b00;
    step(20);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    wait_rx("ferr_ready");
    check("ferr_data", rd_data, 8'h3C);
    check("ferr_err", rd_err, 2'b10);
    pop();
    step(768);
    check("ferr_no_rearm", rx_empty, 1'b1);
    rx_drv = 1'b1;
    step(128);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
    wait_rx("rearm_ready");
    check("rearm_data", rd_data, 8'h5A);
    check("rearm_err", rd_err, 2'b00);
    pop();

    rx_drv = 1'b0;
    step(12);
    rx_drv = 1'b1;
    step(640);
    check("glitch_no_push", rx_empty, 1'b1);

    do_reset();
    for (int i = 1; i <= 4; i++) begin
      send_frame(8'(i * 8'h11), 1'b0, 1'b0, 1'b1);
      step(8);
    end
    check("ovr_full", s_rx_full, 1'b1);
    check("ovr_not_yet", s_rx_overrun, 1'b0);
    send_frame(8'h55, 1'b0, 1'b0, 1'b1);
    step(16);
    check("ovr_set", s_rx_overrun, 1'b1);
    check("ovr_head_kept", s_rd_data, 8'h11);
    s_clr = 1'b1;
    step(1);
    s_clr = 1'b0;
    check("ovr_cleared", s_rx_overrun, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      check("ovr_word", s_rd_data, 8'(i * 8'h11));
      s_rd = 1'b1;
      step(1);
      s_rd = 1'b0;
    end
    check("ovr_empty", s_rx_empty, 1'b1);

    do_reset();
    fork
      begin
        for (int i = 1; i <= 20; i++) begin
          wr_uart = 1'b1;
          wr_data = 8'(i);
          step(1);
        end
        wr_uart = 1'b0;
        check("burst_full", tx_full, 1'b1);
      end
      begin
        for (int k = 1; k <= 17; k++) begin
          tx_recv(1'b0, d, pb, sb, rise, lat);
          check("burst_word", d, 8'(k));
        end
      end
    join
    lows = 0;
    for (int i = 0; i < 700; i++) begin
      step(1);
      if (tx !== 1'b1) lows++;
    end
    check("burst_no_extra", lows, 0);
    check("burst_tx_empty", tx_empty, 1'b1);

    write(8'h81);
    write(8'h42);
    step(200);
    check("midtx_low", tx, 1'b0);
    rst = 1'b1;
    step(1);
    check("midtx_rst_tx", tx, 1'b1);
    check("midtx_rst_empty", tx_empty, 1'b1);
    rst = 1'b0;
    step(100);
    check("midtx_idle", tx, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
